meter_cmd_arbiter: RTL

- Controller that owns the parking meter's remaining-time register and arbitrates every request that modifies it.
- Requesters are four coin/add buttons, two preset buttons and the 1 Hz countdown tick.
- Button inputs are edge-captured into pending flags, then serviced one per cycle by fixed priority.
- Produces BCD digits val1..val4 and status flags for the downstream seven-segment scan/blink logic.

---
 rtl/meter_cmd_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/meter_cmd_arbiter.sv
// meter_cmd_arbiter
//   Owns the parking meter's remaining-time register and arbitrates every
//   request that modifies it. Requests come from four add buttons, two preset
//   buttons and the 1 Hz countdown tick. Button edges are captured into
//   pending flags, and the flags are serviced one per cycle by fixed priority.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   tick       one-cycle 1 Hz countdown enable
//   add1..add4 add-time buttons (level, may be held)
//   rst1, rst2 preset buttons (level, may be held)
//   val1..val4 registered BCD digits of remaining time (val1 = thousands)
//   grant      one-hot pulse naming the command serviced this cycle
//              {rst1, rst2, add4, add3, add2, add1}
//   expired    registered: remaining time == 0
//   low        registered: 0 < remaining time < LOW_THRESH
//   busy       any pending flag set
//   dbg_state  service FSM state (0 = IDLE, 1 = SERVE)
//
// Handshake: there is no back-pressure. A button's rising edge is a request.
// The request is accepted into its pending flag on the next clock edge, and
// the request is retired in the cycle when its grant bit is high.
module meter_cmd_arbiter #(
  parameter int ADD1_SEC   = 60,
  parameter int ADD2_SEC   = 120,
  parameter int ADD3_SEC   = 180,
  parameter int ADD4_SEC   = 300,
  parameter int PRE1_SEC   = 15,
  parameter int PRE2_SEC   = 150,
  parameter int MAX_SEC    = 9999,
  parameter int LOW_THRESH = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       add1,
  input  logic       add2,
  input  logic       add3,
  input  logic       add4,
  input  logic       rst1,
  input  logic       rst2,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [3:0] val4,
  output logic [5:0] grant,
  output logic       expired,
  output logic       low,
  output logic       busy,
  output logic       dbg_state
);

  localparam logic [13:0] L_ADD1 = 14'(ADD1_SEC);
  localparam logic [13:0] L_ADD2 = 14'(ADD2_SEC);
  localparam logic [13:0] L_ADD3 = 14'(ADD3_SEC);
  localparam logic [13:0] L_ADD4 = 14'(ADD4_SEC);
  localparam logic [13:0] L_PRE1 = 14'(PRE1_SEC);
  localparam logic [13:0] L_PRE2 = 14'(PRE2_SEC);
  localparam logic [14:0] L_MAX  = 15'(MAX_SEC);
  localparam logic [13:0] L_LOW  = 14'(LOW_THRESH);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  w_btn;
  logic [5:0]  r_btn_q;
  logic [5:0]  w_rise;
  logic [5:0]  r_pend;
  logic [5:0]  w_pend_nxt;
  logic [5:0]  w_clear;
  logic [5:0]  w_grant;
  logic        r_tick_pend;
  logic        w_tick_pend_nxt;
  logic [13:0] r_count;
  logic [13:0] w_count_nxt;
  logic [13:0] w_add_amt;
  logic [14:0] w_sum;
  logic [15:0] w_bcd;
  logic [15:0] r_val;
  logic        r_expired;
  logic        r_low;

  // Bit order matches the grant vector, so bit index == priority rank.
  assign w_btn  = {rst1, rst2, add4, add3, add2, add1};
  assign w_rise = w_btn & ~r_btn_q;

  // Grant selection and pending-flag update.
  always_comb begin
    w_grant = '0;
    if (r_state == S_SERVE) begin
      // Ascending scan: the highest set bit is written last and wins.
      for (int i = 0; i < 6; i++) begin
        if (r_pend[i]) begin
          w_grant    = '0;
          w_grant[i] = 1'b1;
        end
      end
    end
    // A preset makes every queued add (and the other preset) meaningless.
    w_clear    = (w_grant[5] | w_grant[4]) ? 6'h3F : w_grant;
    // Fresh edges are merged after the clear so none are lost.
    w_pend_nxt = (r_pend & ~w_clear) | w_rise;
  end

  // The FSM moves on the same edge that loads the flags, so a request is
  // granted in the cycle right after its capture. SERVE therefore always
  // has at least one flag to service.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (|w_pend_nxt)  w_state_nxt = S_SERVE;
      S_SERVE: if (~|w_pend_nxt) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Count arithmetic. A tick that collides with a grant is parked in
  // r_tick_pend. A second tick while parked merges into the same decrement.
  always_comb begin
    w_add_amt = '0;
    if (w_grant[3])      w_add_amt = L_ADD4;
    else if (w_grant[2]) w_add_amt = L_ADD3;
    else if (w_grant[1]) w_add_amt = L_ADD2;
    else if (w_grant[0]) w_add_amt = L_ADD1;
    w_sum = {1'b0, r_count} + {1'b0, w_add_amt};

    w_count_nxt = r_count;
    if (w_grant[5])
      w_count_nxt = L_PRE1;
    else if (w_grant[4])
      w_count_nxt = L_PRE2;
    else if (|w_grant[3:0])
      w_count_nxt = (w_sum > L_MAX) ? L_MAX[13:0] : w_sum[13:0];
    else if ((tick | r_tick_pend) && (r_count != 14'd0))
      w_count_nxt = r_count - 14'd1;

    w_tick_pend_nxt = (|w_grant) ? (r_tick_pend | tick) : 1'b0;
  end

  // Binary to BCD by shift-and-add-3; count never exceeds 9999.
  always_comb begin
    w_bcd = '0;
    for (int i = 13; i >= 0; i--) begin
      for (int d = 0; d < 4; d++) begin
        if (w_bcd[4*d +: 4] >= 4'd5)
          w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
      end
      w_bcd = {w_bcd[14:0], r_count[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_btn_q     <= '0;
      r_pend      <= '0;
      r_tick_pend <= 1'b0;
      r_count     <= '0;
      r_val       <= '0;
      r_expired   <= 1'b1;
      r_low       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_btn_q     <= w_btn;
      r_pend      <= w_pend_nxt;
      r_tick_pend <= w_tick_pend_nxt;
      r_count     <= w_count_nxt;
      r_val       <= w_bcd;
      r_expired   <= (r_count == 14'd0);
      r_low       <= (r_count != 14'd0) && (r_count < L_LOW);
    end
  end

  assign val1      = r_val[15:12];
  assign val2      = r_val[11:8];
  assign val3      = r_val[7:4];
  assign val4      = r_val[3:0];
  assign grant     = w_grant;
  assign expired   = r_expired;
  assign low       = r_low;
  assign busy      = |r_pend;
  assign dbg_state = r_state;

endmodule
